// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down counter with press edge detection, hold-to-repeat,
// wrap/saturate limits and registered seven-segment outputs per digit.

module bcd_counter_display_seg #(
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit RST_BLANK  = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [3:0] i_Digit,
    input  logic       i_Blank,
    output logic [6:0] o_Seg
);
    localparam logic [6:0] POL     = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] RST_PAT = RST_BLANK ? 7'h00 : 7'h3F;

    logic [6:0] pat;

    // Patterns are active-high here, bit 0 = A ... bit 6 = G; 10-15 show blank.
    always_comb begin
        pat = 7'h00;
        if (!i_Blank) begin
            case (i_Digit)
                4'd0:    pat = 7'h3F;
                4'd1:    pat = 7'h06;
                4'd2:    pat = 7'h5B;
                4'd3:    pat = 7'h4F;
                4'd4:    pat = 7'h66;
                4'd5:    pat = 7'h6D;
                4'd6:    pat = 7'h7D;
                4'd7:    pat = 7'h07;
                4'd8:    pat = 7'h7F;
                4'd9:    pat = 7'h6F;
                default: pat = 7'h00;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) o_Seg <= RST_PAT ^ POL;
        else          o_Seg <= pat ^ POL;
    end
endmodule

module bcd_counter_display #(
    parameter int NUM_DIGITS     = 2,
    parameter int MAX_VALUE      = 99,
    parameter bit WRAP           = 1'b1,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_RATE    = 2500000,
    parameter bit BLANK_LEADING  = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic                      i_Up,
    input  logic                      i_Down,
    input  logic                      i_Clear,
    output logic [4*NUM_DIGITS-1:0]   o_Count,
    output logic [7*NUM_DIGITS-1:0]   o_Segments,
    output logic                      o_Wrap
);
    if (NUM_DIGITS < 1 || NUM_DIGITS > 4 || MAX_VALUE < 0 ||
        MAX_VALUE > 10**NUM_DIGITS - 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("bcd_counter_display: illegal parameter combination");
    end

    function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int v);
        logic [4*NUM_DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [NUM_DIGITS-1:0][3:0] MAX_BCD = to_bcd(MAX_VALUE);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [TW-1:0] DLY_LOAD  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LOAD = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

    state_t                         state_q, state_d;
    logic [TW-1:0]                  tmr_q, tmr_d;
    logic                           dir_q, dir_d;
    logic                           up_q, dn_q, clr_q;
    logic                           guard_q;
    logic                           up_press, dn_press, clr_press, held;
    logic                           step, step_up, wrap_evt;
    logic [NUM_DIGITS-1:0][3:0]     cnt_q, inc_v, dec_v, nxt_v;
    logic [NUM_DIGITS-1:0]          blank;
    logic [NUM_DIGITS-1:0][6:0]     seg;
    logic                           wrap_q;

    assign up_press  = i_Up & ~up_q;
    assign dn_press  = i_Down & ~dn_q;
    assign clr_press = i_Clear & ~clr_q;
    assign held      = dir_q ? i_Up : i_Down;

    // Ripple BCD increment/decrement; the limit handling picks between them.
    always_comb begin
        logic carry, borrow;
        inc_v  = cnt_q;
        dec_v  = cnt_q;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (inc_v[d] == 4'd9) inc_v[d] = 4'd0;
                else begin
                    inc_v[d] = inc_v[d] + 4'd1;
                    carry    = 1'b0;
                end
            end
            if (borrow) begin
                if (dec_v[d] == 4'd0) dec_v[d] = 4'd9;
                else begin
                    dec_v[d] = dec_v[d] - 4'd1;
                    borrow   = 1'b0;
                end
            end
        end
    end

    always_comb begin
        nxt_v    = cnt_q;
        wrap_evt = 1'b0;
        if (step_up) begin
            if (cnt_q == MAX_BCD) begin
                if (WRAP) begin
                    nxt_v    = '0;
                    wrap_evt = 1'b1;
                end
            end else begin
                nxt_v = inc_v;
            end
        end else begin
            if (cnt_q == '0) begin
                if (WRAP) begin
                    nxt_v    = MAX_BCD;
                    wrap_evt = 1'b1;
                end
            end else begin
                nxt_v = dec_v;
            end
        end
    end

    // LOCK holds off after a two-button chord until both are released.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        dir_d   = dir_q;
        step    = 1'b0;
        step_up = dir_q;
        if (clr_press) begin
            state_d = IDLE;
        end else if (i_Up && i_Down) begin
            state_d = LOCK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!guard_q && (up_press || dn_press)) begin
                        step    = 1'b1;
                        step_up = up_press;
                        dir_d   = up_press;
                        tmr_d   = DLY_LOAD;
                        state_d = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (!held) begin
                        state_d = IDLE;
                    end else if (tmr_q == '0) begin
                        step    = 1'b1;
                        tmr_d   = RATE_LOAD;
                        state_d = REPEAT;
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                LOCK: begin
                    if (!i_Up && !i_Down) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // guard_q suppresses a false press when a button is still held as reset releases.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            clr_q   <= 1'b0;
            guard_q <= 1'b1;
            state_q <= IDLE;
            tmr_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            up_q    <= i_Up;
            dn_q    <= i_Down;
            clr_q   <= i_Clear;
            guard_q <= guard_q & (i_Up | i_Down);
            state_q <= state_d;
            tmr_q   <= tmr_d;
            dir_q   <= dir_d;
            wrap_q  <= 1'b0;
            if (clr_press) begin
                cnt_q <= '0;
            end else if (step) begin
                cnt_q  <= nxt_v;
                wrap_q <= wrap_evt;
            end
        end
    end

    always_comb begin
        logic zero_up;
        blank   = '0;
        zero_up = 1'b1;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            zero_up  = zero_up && (cnt_q[d] == 4'd0);
            blank[d] = BLANK_LEADING && zero_up;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        bcd_counter_display_seg #(
            .ACTIVE_LOW (SEG_ACTIVE_LOW),
            .RST_BLANK  (BLANK_LEADING && (g > 0))
        ) u_seg (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .i_Digit (cnt_q[g]),
            .i_Blank (blank[g]),
            .o_Seg   (seg[g])
        );
    end

    assign o_Count    = cnt_q;
    assign o_Segments = seg;
    assign o_Wrap     = wrap_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Drives a wrapping/zero-padded and a saturating/blanking counter with the
// same buttons and compares both against a cycle-level behavioural model.

module tb_bcd_counter_display;
    localparam int MAXV = 99;
    localparam int DLY  = 8;
    localparam int RATE = 3;
    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam bit WR [2] = '{1'b1, 1'b0};
    localparam bit BL [2] = '{1'b0, 1'b1};

    logic        clk = 1'b0, rst_n = 1'b0, up = 1'b0, dn = 1'b0, clr = 1'b0;
    logic [7:0]  cnt_w, cnt_s;
    logic [13:0] seg_w, seg_s;
    logic        wr_w, wr_s;

    int n_chk = 0, n_pass = 0;

    int   m_cnt [2];
    bit   m_wr  [2];
    logic [13:0] m_seg [2];
    bit   p_u, p_d, p_c, m_guard, m_lock;
    int   m_act, m_age;

    always #5 clk = ~clk;

    bcd_counter_display #(.NUM_DIGITS(2), .MAX_VALUE(MAXV), .WRAP(1'b1), .REPEAT_DELAY(DLY),
        .REPEAT_RATE(RATE), .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_w (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Up(up), .i_Down(dn), .i_Clear(clr),
        .o_Count(cnt_w), .o_Segments(seg_w), .o_Wrap(wr_w));

    bcd_counter_display #(.NUM_DIGITS(2), .MAX_VALUE(MAXV), .WRAP(1'b0), .REPEAT_DELAY(DLY),
        .REPEAT_RATE(RATE), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_s (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Up(up), .i_Down(dn), .i_Clear(clr),
        .o_Count(cnt_s), .o_Segments(seg_s), .o_Wrap(wr_s));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] bcd(input int c);
        return 8'(((c / 10) << 4) | (c % 10));
    endfunction

    function automatic logic [13:0] dec(input int c, input bit bl);
        logic [13:0] r;
        int dg;
        r = '0;
        for (int d = 0; d < 2; d++) begin
            dg = (d == 0) ? c % 10 : c / 10;
            if (d > 0 && bl && c < 10) r[7*d +: 7] = 7'h7F;
            else                       r[7*d +: 7] = ~PAT[dg];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_wr[i]  = 1'b0;
            m_seg[i] = dec(0, BL[i]);
        end
        p_u = 0; p_d = 0; p_c = 0;
        m_guard = 1; m_lock = 0; m_act = 0; m_age = 0;
    endtask

    // One clock edge: step happens on a press, then DLY cycles of holding,
    // then every RATE cycles while the same button stays down.
    task automatic model_edge(input bit u, input bit d, input bit c);
        int st;
        st = 0;
        for (int i = 0; i < 2; i++) begin
            m_seg[i] = dec(m_cnt[i], BL[i]);
            m_wr[i]  = 1'b0;
        end
        if (c && !p_c) begin
            m_cnt[0] = 0; m_cnt[1] = 0;
            m_act = 0; m_lock = 0;
        end else if (u && d) begin
            m_act = 0; m_lock = 1;
        end else if (m_lock) begin
            if (!u && !d) m_lock = 0;
        end else if (m_act != 0) begin
            if ((m_act == 1) ? u : d) begin
                m_age++;
                if (m_age == DLY || (m_age > DLY && (m_age - DLY) % RATE == 0))
                    st = (m_act == 1) ? 1 : -1;
            end else begin
                m_act = 0;
            end
        end else if (!m_guard) begin
            if (u && !p_u)      begin m_act = 1; m_age = 0; st = 1;  end
            else if (d && !p_d) begin m_act = 2; m_age = 0; st = -1; end
        end
        for (int i = 0; i < 2; i++) begin
            if (st == 1) begin
                if (m_cnt[i] == MAXV) begin
                    if (WR[i]) begin m_cnt[i] = 0; m_wr[i] = 1'b1; end
                end else m_cnt[i]++;
            end else if (st == -1) begin
                if (m_cnt[i] == 0) begin
                    if (WR[i]) begin m_cnt[i] = MAXV; m_wr[i] = 1'b1; end
                end else m_cnt[i]--;
            end
        end
        m_guard = m_guard && (u || d);
        p_u = u; p_d = d; p_c = c;
    endtask

    task automatic cmp_all();
        chk("cnt_w", cnt_w, bcd(m_cnt[0]));
        chk("cnt_s", cnt_s, bcd(m_cnt[1]));
        chk("wrap_w", wr_w, m_wr[0]);
        chk("wrap_s", wr_s, m_wr[1]);
        chk("seg_w", seg_w, m_seg[0]);
        chk("seg_s", seg_s, m_seg[1]);
    endtask

    task automatic cyc(input bit u, input bit d, input bit c);
        up = u; dn = d; clr = c;
        model_edge(u, d, c);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press_up();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
    endtask

    initial begin
        bit ru, rd;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        cmp_all();
        chk("rst_cnt", cnt_w, 8'h00);
        chk("rst_seg", seg_w, 14'h2040);
        chk("rst_seg_blank", seg_s, 14'h3FC0);
        chk("rst_wrap", wr_w, 1'b0);
        rst_n = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        cyc(1, 0, 0);
        chk("short_cnt", cnt_w, 8'h01);
        cyc(1, 0, 0);
        chk("short_seg", seg_w[6:0], 7'h79);
        repeat (3) cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);
        chk("short_hold", cnt_w, 8'h01);

        cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("clear", cnt_w, 8'h00);
        repeat (20) cyc(1, 0, 0);
        chk("hold20", cnt_w, 8'h05);
        repeat (5) cyc(0, 0, 0);
        chk("hold_release", cnt_w, 8'h05);

        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("dn_wrap_cnt", cnt_w, 8'h99);
        chk("dn_wrap_pulse", wr_w, 1'b1);
        chk("dn_sat_cnt", cnt_s, 8'h00);
        chk("dn_sat_nopulse", wr_s, 1'b0);
        cyc(0, 0, 0);
        chk("wrap_one_cycle", wr_w, 1'b0);
        cyc(1, 0, 0);
        chk("up_wrap_cnt", cnt_w, 8'h00);
        chk("up_wrap_pulse", wr_w, 1'b1);
        cyc(0, 0, 0);
        repeat (98) press_up();
        chk("sat_reach", cnt_s, 8'h99);
        cyc(1, 0, 0);
        chk("up_sat_cnt", cnt_s, 8'h99);
        chk("up_sat_nopulse", wr_s, 1'b0);
        cyc(0, 0, 0);

        cyc(0, 0, 1);
        cyc(0, 0, 0);
        repeat (9) press_up();
        chk("nine", cnt_w, 8'h09);
        chk("nine_seg", seg_w[6:0], 7'h10);
        chk("lead_blank", seg_s[13:7], 7'h7F);
        chk("lead_zero", seg_w[13:7], 7'h40);
        cyc(1, 0, 0);
        chk("bcd_carry", cnt_w, 8'h10);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("bcd_borrow", cnt_w, 8'h09);
        cyc(0, 0, 0);

        cyc(1, 1, 0);
        chk("chord", cnt_w, 8'h09);
        cyc(1, 0, 0);
        chk("chord_lock", cnt_w, 8'h09);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("chord_exit", cnt_w, 8'h10);
        cyc(0, 0, 0);

        cyc(0, 0, 1);
        cyc(0, 0, 0);
        repeat (12) cyc(1, 0, 0);
        chk("repeat_pre", cnt_w, 8'h03);
        cyc(1, 0, 1);
        chk("repeat_clear", cnt_w, 8'h00);
        repeat (10) cyc(1, 0, 0);
        chk("repeat_stopped", cnt_w, 8'h00);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("repress", cnt_w, 8'h01);

        repeat (4) cyc(1, 0, 0);
        do_reset();
        chk("rst_mid_delay", cnt_w, 8'h00);
        repeat (12) cyc(1, 0, 0);
        chk("rst_no_step", cnt_w, 8'h00);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("rst_repress", cnt_w, 8'h01);
        cyc(0, 0, 0);

        ru = 0;
        rd = 0;
        repeat (3000) begin
            if ($urandom_range(7) == 0) ru = !ru;
            if ($urandom_range(9) == 0) rd = !rd;
            if ($urandom_range(399) == 0) do_reset();
            else cyc(ru, rd, $urandom_range(29) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
